// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one ALU among N_REQ requesters.
// Each requester has its own one-entry result register.

package riscv_pkg;
  localparam int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  typedef struct packed {
    alu_op_t         op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } alu_in_t;

  typedef struct packed {
    logic [XLEN-1:0] y;
    logic            zero;
  } alu_out_t;
endpackage

module riscv_alu
  import riscv_pkg::*;
(
  input  alu_in_t  i_in,
  output alu_out_t o_out
);
  localparam int unsigned SH_W = $clog2(XLEN);

  logic [SH_W-1:0] w_shamt;
  logic [XLEN-1:0] w_y;

  assign w_shamt = i_in.b[SH_W-1:0];

  always_comb begin
    w_y = '0;
    case (i_in.op)
      ALU_ADD:  w_y = i_in.a + i_in.b;
      ALU_SUB:  w_y = i_in.a - i_in.b;
      ALU_SLL:  w_y = i_in.a << w_shamt;
      ALU_SLT:  w_y = XLEN'($signed(i_in.a) < $signed(i_in.b));
      ALU_SLTU: w_y = XLEN'(i_in.a < i_in.b);
      ALU_XOR:  w_y = i_in.a ^ i_in.b;
      ALU_SRL:  w_y = i_in.a >> w_shamt;
      ALU_SRA:  w_y = XLEN'($signed(i_in.a) >>> w_shamt);
      ALU_OR:   w_y = i_in.a | i_in.b;
      ALU_AND:  w_y = i_in.a & i_in.b;
      default:  w_y = '0;
    endcase
  end

  assign o_out.y    = w_y;
  assign o_out.zero = (w_y == '0);
endmodule

module alu_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned N_REQ = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N_REQ-1:0]    req_valid_i,
  output logic [N_REQ-1:0]    req_ready_o,
  input  alu_op_t             req_op_i [N_REQ],
  input  logic [XLEN-1:0]     req_a_i  [N_REQ],
  input  logic [XLEN-1:0]     req_b_i  [N_REQ],
  output logic [N_REQ-1:0]    rsp_valid_o,
  input  logic [N_REQ-1:0]    rsp_ready_i,
  output logic [XLEN-1:0]     rsp_y_o  [N_REQ],
  output logic [N_REQ-1:0]    rsp_zero_o
);
  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] r_last;
  logic [N_REQ-1:0] r_rsp_valid;
  logic [N_REQ-1:0] r_rsp_zero;
  logic [XLEN-1:0]  r_rsp_y [N_REQ];

  logic [N_REQ-1:0] w_elig;
  logic [N_REQ-1:0] w_grant;
  logic [IDX_W-1:0] w_gnt_idx;
  logic             w_gnt_any;
  logic             w_gnt_vld;
  alu_in_t          w_alu_in;
  alu_out_t         w_alu_out;

  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base,
                                              input int unsigned off);
    return IDX_W'((32'(base) + off) % N_REQ);
  endfunction

  // A port may accept only if its result slot is empty or being drained now.
  assign w_elig = req_valid_i & (~r_rsp_valid | rsp_ready_i);

  // Round-robin search starting just after the last granted port.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      if (!w_gnt_any && w_elig[rr_idx(r_last, k)]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = rr_idx(r_last, k);
      end
    end
  end

  assign w_gnt_vld   = w_gnt_any & rst_ni;
  assign w_grant     = w_gnt_vld ? (N_REQ'(1) << w_gnt_idx) : '0;
  assign req_ready_o = w_grant;

  always_comb begin
    w_alu_in.op = ALU_ADD;
    w_alu_in.a  = '0;
    w_alu_in.b  = '0;
    if (w_gnt_vld) begin
      w_alu_in.op = req_op_i[w_gnt_idx];
      w_alu_in.a  = req_a_i[w_gnt_idx];
      w_alu_in.b  = req_b_i[w_gnt_idx];
    end
  end

  riscv_alu u_alu (
    .i_in  (w_alu_in),
    .o_out (w_alu_out)
  );

  // Pointer and per-port result registers; a grant wins over a drain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last      <= IDX_W'(N_REQ - 1);
      r_rsp_valid <= '0;
      r_rsp_zero  <= '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        r_rsp_y[i] <= '0;
      end
    end else begin
      if (w_gnt_vld) begin
        r_last <= w_gnt_idx;
      end
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (w_grant[i]) begin
          r_rsp_valid[i] <= 1'b1;
          r_rsp_y[i]     <= w_alu_out.y;
          r_rsp_zero[i]  <= w_alu_out.zero;
        end else if (rsp_ready_i[i]) begin
          r_rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_zero_o  = r_rsp_zero;
  assign rsp_y_o     = r_rsp_y;
endmodule
